uart_time_tx: RTL and testbench

Transmit-side companion of the UART time-setting path. Snapshots the running BCD time (Hour/Minute/Seconds from the clock generator) and sends it on a UART line as the 10-byte ASCII frame "HH:MM:SS\r\n", 8N1, LSB first. A frame starts on a host request or, optionally, automatically on every change of Seconds. Sits beside the clock generator and shares the board's Baud_Set switches with the receiver.

---
 rtl/uart_time_tx_pkg.sv | 78 +++++++
 rtl/uart_time_tx_byte_tx.sv | 116 +++++++++++
 rtl/uart_time_tx.sv | 179 +++++++++++++++++
 tb/tb_uart_time_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_time_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_time_tx_pkg
// Shared definitions for the UART time path: baud divisor table, ASCII
// constants used in the "HH:MM:SS\r\n" frame, the frame FSM state encoding
// and the byte-map helper that turns a byte index into the character to send.
// The divisor table is also used by the receiver, so both ends agree on the
// Baud_Set decoding.
// -----------------------------------------------------------------------------
package uart_time_tx_pkg;

  // Width of the per-bit cycle counter; covers 9600 baud up to ~10 GHz clocks.
  localparam int BAUD_W = 20;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  // Index of the LF byte, the last byte of a frame.
  localparam logic [3:0] LAST_IDX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_NEXT = 2'd3
  } frame_state_e;

  // Clock cycles per UART bit, integer floor of clk_freq / baud.
  // Unused selector codes fall back to 9600 baud.
  function automatic logic [BAUD_W-1:0] baud_cycles(input int unsigned clk_freq,
                                                    input logic [2:0]  baud_sel);
    int unsigned div;
    case (baud_sel)
      3'd1:    div = clk_freq / 32'd19200;
      3'd2:    div = clk_freq / 32'd38400;
      3'd3:    div = clk_freq / 32'd57600;
      3'd4:    div = clk_freq / 32'd115200;
      default: div = clk_freq / 32'd9600;
    endcase
    return div[BAUD_W-1:0];
  endfunction

  // One BCD nibble as an ASCII digit; non-decimal nibbles show up as '?'.
  function automatic logic [7:0] ascii_digit(input logic [3:0] nib);
    logic [7:0] chr;
    if (nib <= 4'd9) begin
      chr = ASCII_ZERO + {4'h0, nib};
    end else begin
      chr = ASCII_QMARK;
    end
    return chr;
  endfunction

  // Character at position idx of "HH:MM:SS\r\n".
  function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                            input logic [7:0] hour,
                                            input logic [7:0] minute,
                                            input logic [7:0] second);
    logic [7:0] chr;
    case (idx)
      4'd0:    chr = ascii_digit(hour[7:4]);
      4'd1:    chr = ascii_digit(hour[3:0]);
      4'd2:    chr = ASCII_COLON;
      4'd3:    chr = ascii_digit(minute[7:4]);
      4'd4:    chr = ascii_digit(minute[3:0]);
      4'd5:    chr = ASCII_COLON;
      4'd6:    chr = ascii_digit(second[7:4]);
      4'd7:    chr = ascii_digit(second[3:0]);
      4'd8:    chr = ASCII_CR;
      4'd9:    chr = ASCII_LF;
      default: chr = ASCII_QMARK;
    endcase
    return chr;
  endfunction

endpackage

// File: rtl/uart_time_tx_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Single-byte 8N1 transmitter, LSB first. A Send_En pulse while idle latches
// Data and the baud selection; the line then carries start, 8 data and stop
// bits of exactly BIT_CYC cycles each, starting the cycle after Send_En.
//
// Ports
//   Clk       in   system clock, rising edge
//   Reset     in   asynchronous, active-high
//   Send_En   in   start one byte (ignored while busy)
//   Data      in   byte to send
//   Baud_Set  in   rate select, latched with Send_En
//   uart_tx   out  serial line, idle high
//   Tx_Done   out  high in the last cycle of the stop bit
//   Tx_Busy   out  high while a byte is on the line
// -----------------------------------------------------------------------------
module uart_byte_tx
  import uart_time_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Send_En,
  input  logic [7:0] Data,
  input  logic [2:0] Baud_Set,
  output logic       uart_tx,
  output logic       Tx_Done,
  output logic       Tx_Busy
);

  logic              busy_q,     busy_d;
  logic              tx_q,       tx_d;
  logic              done_q,     done_d;
  logic [3:0]        bit_cnt_q,  bit_cnt_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [BAUD_W-1:0] bit_cyc_q,  bit_cyc_d;
  logic [7:0]        shift_q,    shift_d;
  logic              bit_end_s;

  // bit_cnt: 0 = start, 1..8 = data, 9 = stop
  assign bit_end_s = (baud_cnt_q == (bit_cyc_q - BAUD_W'(1)));

  // Next-state logic for the bit/baud counters, shifter and line driver
  always_comb begin
    busy_d     = busy_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    bit_cyc_d  = bit_cyc_q;
    shift_d    = shift_q;
    if (!busy_q) begin
      if (Send_En) begin
        busy_d     = 1'b1;
        tx_d       = 1'b0;
        bit_cnt_d  = 4'd0;
        baud_cnt_d = '0;
        bit_cyc_d  = baud_cycles(CLK_FREQ, Baud_Set);
        shift_d    = Data;
      end else begin
        tx_d = 1'b1;
      end
    end else begin
      if (bit_end_s) begin
        baud_cnt_d = '0;
        if (bit_cnt_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          tx_d      = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end
      end else begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
      end
      // Raised one cycle early so the flop output lines up with the final
      // stop-bit cycle.
      if ((bit_cnt_q == 4'd9) && (baud_cnt_q == (bit_cyc_q - BAUD_W'(2)))) begin
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end
  end

  // State registers; the line is forced high by reset at once
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= '0;
      bit_cyc_q  <= '0;
      shift_q    <= 8'h00;
    end else begin
      busy_q     <= busy_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cyc_q  <= bit_cyc_d;
      shift_q    <= shift_d;
    end
  end

  assign uart_tx = tx_q;
  assign Tx_Done = done_q;
  assign Tx_Busy = busy_q;

endmodule

// File: rtl/uart_time_tx.sv
// -----------------------------------------------------------------------------
// uart_time_tx
// Sends the running BCD time as the ASCII frame "HH:MM:SS\r\n" (8N1, LSB
// first). A frame is requested by Send_Go or, with Auto_En, by any change of
// Seconds. Time and baud selection are snapshotted at frame start, so a frame
// is never torn and a baud change only affects the next frame.
//
// Ports
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous, active-high
//   Baud_Set     in   0=9600 1=19200 2=38400 3=57600 4=115200 else 9600
//   Hour/Minute/Seconds in  packed BCD time
//   Send_Go      in   one-cycle frame request
//   Auto_En      in   also request a frame on every Seconds change
//   uart_tx      out  serial line, idle high
//   Busy         out  high from frame acceptance until Frame_Done
//   Frame_Done   out  one-cycle pulse in the last cycle of the LF stop bit
// -----------------------------------------------------------------------------
module uart_time_tx
  import uart_time_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Baud_Set,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Seconds,
  input  logic       Send_Go,
  input  logic       Auto_En,
  output logic       uart_tx,
  output logic       Busy,
  output logic       Frame_Done
);

  frame_state_e state_q;
  logic [3:0]   idx_q;
  logic         send_en_q;
  logic         busy_q;
  logic [7:0]   hour_q, min_q, sec_q;
  logic [2:0]   baud_q;
  logic [7:0]   sec_prev_q;
  logic         pending_q, pending_d;

  logic         auto_stb_s;
  logic         req_s;
  logic         tx_done_s;
  logic         tx_busy_s;
  logic         frame_done_s;
  logic [7:0]   byte_s;
  logic [2:0]   baud_s;

  assign auto_stb_s = Auto_En && (Seconds != sec_prev_q);
  assign req_s      = Send_Go || auto_stb_s;

  // Previous-cycle Seconds for the auto strobe
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sec_prev_q <= 8'h00;
    end else begin
      sec_prev_q <= Seconds;
    end
  end

  // A new request wins over the LOAD clear, so one arriving during LOAD
  // produces a follow-up frame.
  always_comb begin
    if (req_s) begin
      pending_d = 1'b1;
    end else if (state_q == S_LOAD) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Pending-request flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Byte mux. The first byte is handed over during LOAD, the same cycle the
  // shadows are written, so it takes the live inputs that the shadows capture.
  always_comb begin
    if (state_q == S_LOAD) begin
      byte_s = frame_byte(4'd0, Hour, Minute, Seconds);
      baud_s = Baud_Set;
    end else begin
      byte_s = frame_byte(idx_q, hour_q, min_q, sec_q);
      baud_s = baud_q;
    end
  end

  // Frame FSM. Send_En is a flop: raised on entry to LOAD for byte 0 and on
  // leaving NEXT for later bytes, which leaves two idle-high cycles between
  // one stop bit and the next start bit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      send_en_q <= 1'b0;
      busy_q    <= 1'b0;
      hour_q    <= 8'h00;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      baud_q    <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if ((pending_q || req_s) && !tx_busy_s) begin
            state_q   <= S_LOAD;
            send_en_q <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            send_en_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        S_LOAD: begin
          hour_q    <= Hour;
          min_q     <= Minute;
          sec_q     <= Seconds;
          baud_q    <= Baud_Set;
          idx_q     <= 4'd0;
          send_en_q <= 1'b0;
          state_q   <= S_SEND;
        end
        S_SEND: begin
          send_en_q <= 1'b0;
          if (tx_done_s) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_NEXT;
            end
          end else begin
            state_q <= S_SEND;
          end
        end
        S_NEXT: begin
          idx_q     <= idx_q + 4'd1;
          send_en_q <= 1'b1;
          state_q   <= S_SEND;
        end
        default: begin
          state_q   <= S_IDLE;
          send_en_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Tx_Done is itself a flop, so this decode is aligned with the LF stop bit.
  assign frame_done_s = (state_q == S_SEND) && tx_done_s && (idx_q == LAST_IDX);

  uart_byte_tx #(
    .CLK_FREQ(CLK_FREQ)
  ) u_byte_tx (
    .Clk      (Clk),
    .Reset    (Reset),
    .Send_En  (send_en_q),
    .Data     (byte_s),
    .Baud_Set (baud_s),
    .uart_tx  (uart_tx),
    .Tx_Done  (tx_done_s),
    .Tx_Busy  (tx_busy_s)
  );

  assign Busy       = busy_q;
  assign Frame_Done = frame_done_s;

endmodule

// File: tb/tb_uart_time_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_time_tx
// Stimulus pushes the hand-computed frame bytes into exp_q; an independent
// line monitor decodes uart_tx and pops/compares each received byte.
// CLK_FREQ is reduced so that Baud_Set=4 gives 10-cycle bits and
// Baud_Set=0 gives 120-cycle bits.
// -----------------------------------------------------------------------------
module tb_uart_time_tx;

  localparam int unsigned CLK_FREQ = 1_152_000;
  localparam int B_FAST = 10;   // 1152000/115200
  localparam int B_SLOW = 120;  // 1152000/9600

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] Baud_Set = 3'd4;
  logic [7:0] Hour = 8'h00;
  logic [7:0] Minute = 8'h00;
  logic [7:0] Seconds = 8'h00;
  logic       Send_Go = 1'b0;
  logic       Auto_En = 1'b0;
  logic       uart_tx;
  logic       Busy;
  logic       Frame_Done;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int mon_bit = B_FAST;
  logic [7:0] exp_q[$];

  uart_time_tx #(.CLK_FREQ(CLK_FREQ)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Baud_Set   (Baud_Set),
    .Hour       (Hour),
    .Minute     (Minute),
    .Seconds    (Seconds),
    .Send_Go    (Send_Go),
    .Auto_En    (Auto_En),
    .uart_tx    (uart_tx),
    .Busy       (Busy),
    .Frame_Done (Frame_Done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Line monitor: samples each bit in its middle and scores the byte.
  logic       mon_active = 1'b0;
  int         mon_pos = 0;
  int         mon_b = B_FAST;
  int         mon_k = 0;
  logic [7:0] mon_sh = 8'h00;

  always @(negedge Clk) begin
    if (Reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_pos = 0;
        mon_b = mon_bit;
      end
    end else begin
      mon_pos++;
      if (mon_pos % mon_b == mon_b / 2) begin
        mon_k = mon_pos / mon_b;
        if (mon_k == 0) begin
          check("start_bit", int'(uart_tx), 0);
        end else if (mon_k <= 8) begin
          mon_sh = {uart_tx, mon_sh[7:1]};
        end else begin
          check("stop_bit", int'(uart_tx), 1);
          check("byte_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("rx_byte", int'(mon_sh), int'(exp_q.pop_front()));
          mon_active = 1'b0;
        end
      end
    end
  end

  // Expected frame given as 10 bytes, first byte in the top bits.
  task automatic push_frame(input logic [79:0] f);
    for (int i = 9; i >= 0; i--) exp_q.push_back(f[i*8 +: 8]);
  endtask

  // Called right after the negedge on which the trigger was applied (cycle N).
  task automatic watch_frame(input int b, input int first_low);
    int t_start;
    int lowc;
    int guard;
    @(negedge Clk);
    Send_Go = 1'b0;
    check("busy_in_load", int'(Busy), 1);
    check("tx_high_in_load", int'(uart_tx), 1);
    @(negedge Clk);
    check("start_fall", int'(uart_tx), 0);
    t_start = cyc;
    lowc = 0;
    while (uart_tx === 1'b0 && lowc < 4 * b) begin
      lowc++;
      @(negedge Clk);
    end
    check("first_low_len", lowc, first_low);
    guard = 0;
    while (Frame_Done !== 1'b1 && guard < 110 * b + 100) begin
      @(negedge Clk);
      guard++;
    end
    check("frame_done_seen", int'(Frame_Done), 1);
    check("busy_at_done", int'(Busy), 1);
    check("frame_len", cyc - t_start + 1, 100 * b + 18);
    @(negedge Clk);
    check("busy_fall", int'(Busy), 0);
    check("done_one_cycle", int'(Frame_Done), 0);
  endtask

  task automatic quiet(input string name, input int n);
    bit ok = 1'b1;
    repeat (n) begin
      @(negedge Clk);
      if (uart_tx !== 1'b1 || Busy !== 1'b0) ok = 1'b0;
    end
    check(name, int'(ok), 1);
  endtask

  initial begin
    repeat (400000) @(posedge Clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_tx", int'(uart_tx), 1);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Frame_Done), 0);
    Reset = 1'b0;
    quiet("idle_after_por", 5);

    // 12:34:56 at 115200
    Hour = 8'h12; Minute = 8'h34; Seconds = 8'h56; Baud_Set = 3'd4; mon_bit = B_FAST;
    push_frame(80'h3132_3A33_343A_3536_0D0A);
    @(negedge Clk); Send_Go = 1'b1;
    watch_frame(B_FAST, B_FAST);

    // 23:59:59 at 9600, baud switch mid-frame is ignored
    Hour = 8'h23; Minute = 8'h59; Seconds = 8'h59; Baud_Set = 3'd0; mon_bit = B_SLOW;
    push_frame(80'h3233_3A35_393A_3539_0D0A);
    @(negedge Clk); Send_Go = 1'b1;
    fork
      watch_frame(B_SLOW, 2 * B_SLOW);
      begin
        repeat (3000) @(negedge Clk);
        Baud_Set = 3'd4;
      end
    join
    mon_bit = B_FAST;

    // Auto frame on Seconds 07->08, three Send_Go pulses collapse into one
    Hour = 8'h10; Minute = 8'h20; Seconds = 8'h07;
    repeat (5) @(negedge Clk);
    Auto_En = 1'b1;
    quiet("no_auto_without_change", 5);
    push_frame(80'h3130_3A32_303A_3038_0D0A);
    push_frame(80'h3130_3A32_303A_3038_0D0A);
    @(negedge Clk); Seconds = 8'h08;
    fork
      watch_frame(B_FAST, B_FAST);
      begin
        for (int k = 0; k < 3; k++) begin
          repeat (200) @(negedge Clk);
          Send_Go = 1'b1;
          @(negedge Clk);
          Send_Go = 1'b0;
        end
      end
    join
    watch_frame(B_FAST, B_FAST);
    quiet("no_third_frame", 300);
    Auto_En = 1'b0;

    // Non-decimal nibble and tear-free snapshot
    Hour = 8'h1A; Minute = 8'h00;
    push_frame(80'h313F_3A30_303A_3038_0D0A);
    @(negedge Clk); Send_Go = 1'b1;
    fork
      watch_frame(B_FAST, B_FAST);
      begin
        repeat (300) @(negedge Clk);
        Hour = 8'h11;
      end
    join

    // Reset during byte 4 (data bit 0 of '4' is low)
    Hour = 8'h12; Minute = 8'h34; Seconds = 8'h56;
    push_frame(80'h3132_3A33_343A_3536_0D0A);
    @(negedge Clk); Send_Go = 1'b1;
    @(negedge Clk); Send_Go = 1'b0;
    @(negedge Clk);
    check("t5_start", int'(uart_tx), 0);
    repeat (4 * (10 * B_FAST + 2) + B_FAST + B_FAST / 2) @(negedge Clk);
    check("pre_reset_low", int'(uart_tx), 0);
    #1 Reset = 1'b1;
    #1;
    check("reset_tx_high", int'(uart_tx), 1);
    check("reset_busy_low", int'(Busy), 0);
    exp_q.delete();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    quiet("idle_after_reset", 200);
    push_frame(80'h3132_3A33_343A_3536_0D0A);
    @(negedge Clk); Send_Go = 1'b1;
    watch_frame(B_FAST, B_FAST);

    // Send_Go and auto strobe in the same idle cycle give one frame
    push_frame(80'h3132_3A33_343A_3537_0D0A);
    @(negedge Clk); Send_Go = 1'b1; Auto_En = 1'b1; Seconds = 8'h57;
    watch_frame(B_FAST, B_FAST);
    quiet("single_frame", 300);
    Auto_En = 1'b0;

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
